// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Pays out a change amount as a greedy sequence of physical coins, one coin
// per valid/ready handshake with the coin ejector, then pulses done to the
// vending controller.
//
// Optional feature macro: CHANGE_DISP_COIN2_EN
//   defined     -> coin set {10,5,2,1}; coin_type 3 (2-unit) takes part in the
//                  greedy choice between 5 and 1.
//   not defined -> coin set {10,5,1}; coin_type 3 is never produced.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   start       payout request, accepted only while busy=0
//   change      amount to pay (W bits), sampled on the accepting edge only
//   coin_ready  ejector ready; a coin transfers on an edge with valid&ready
//   coin_valid  coin request to the ejector (high for the whole ISSUE state)
//   coin_type   0=1-unit, 1=5-unit, 2=10-unit, 3=2-unit
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   remaining   amount still to pay
//   coin_count  coins transferred in the current/last transaction
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int W  = 5,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  change,
    input  logic          coin_ready,
    output logic          coin_valid,
    output logic [1:0]    coin_type,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  remaining,
    output logic [CW-1:0] coin_count
);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    typedef enum logic [1:0] {
        COIN1  = 2'd0,
        COIN5  = 2'd1,
        COIN10 = 2'd2,
        COIN2  = 2'd3
    } coin_t;

    localparam logic [W-1:0] VAL1  = W'(1);
    localparam logic [W-1:0] VAL2  = W'(2);
    localparam logic [W-1:0] VAL5  = W'(5);
    localparam logic [W-1:0] VAL10 = W'(10);

    function automatic logic [W-1:0] coin_value(input coin_t c);
        case (c)
            COIN10:  coin_value = VAL10;
            COIN5:   coin_value = VAL5;
            COIN2:   coin_value = VAL2;
            default: coin_value = VAL1;
        endcase
    endfunction

    state_t          state, state_d;
    coin_t           coin_q, coin_d, coin_sel;
    logic [W-1:0]    remaining_d;
    logic [CW-1:0]   count_d;

    // Greedy choice: the largest available coin not exceeding what is left.
    always_comb begin
        coin_sel = COIN1;
        if (remaining >= VAL10)
            coin_sel = COIN10;
        else if (remaining >= VAL5)
            coin_sel = COIN5;
`ifdef CHANGE_DISP_COIN2_EN
        else if (remaining >= VAL2)
            coin_sel = COIN2;
`endif
    end

    // NOTE: every variable gets its hold value before the case statement so
    // that no path through this block leaves it unassigned (no latches).
    always_comb begin
        state_d     = state;
        coin_d      = coin_q;
        remaining_d = remaining;
        count_d     = coin_count;
        case (state)
            IDLE: begin
                if (start) begin
                    remaining_d = change;
                    count_d     = '0;
                    state_d     = (change == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                coin_d  = coin_sel;
                state_d = ISSUE;
            end
            ISSUE: begin
                // coin_type is frozen here until the ejector takes the coin.
                if (coin_ready) begin
                    remaining_d = remaining - coin_value(coin_q);
                    count_d     = coin_count + CW'(1);
                    state_d     = (remaining_d == '0) ? DONE : SELECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            coin_q     <= COIN1;
            remaining  <= '0;
            coin_count <= '0;
        end else begin
            state      <= state_d;
            coin_q     <= coin_d;
            remaining  <= remaining_d;
            coin_count <= count_d;
        end
    end

    // Status outputs decode straight from the state register, so an
    // asynchronous reset withdraws an outstanding coin request at once.
    assign coin_valid = (state == ISSUE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign coin_type  = coin_q;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Self-checking bench for change_dispenser. A transaction-level model turns
// each accepted amount into its greedy coin list with plain division, then a
// per-cycle compare process follows the handshakes seen on the ejector port
// and checks every output. Directed transactions add literal expectations for
// coin sequences, counts and accept-to-done latency.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int W  = 5;
    localparam int CW = 4;
`ifdef CHANGE_DISP_COIN2_EN
    localparam bit COIN2 = 1'b1;
`else
    localparam bit COIN2 = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  change;
    logic          coin_ready;
    logic          coin_valid;
    logic [1:0]    coin_type;
    logic          busy;
    logic          done;
    logic [W-1:0]  remaining;
    logic [CW-1:0] coin_count;

    change_dispenser #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .change     (change),
        .coin_ready (coin_ready),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .coin_count (coin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    int   exp_q[$];      // coin types still owed, in greedy order
    int   obs_q[$];      // coin types actually transferred this transaction
    int   exp_rem  = 0;
    int   exp_cnt  = 0;
    bit   active   = 0;  // a transaction occupies the DUT this cycle
    bit   done_due = 0;  // this cycle must carry the done pulse
    bit   done_seen = 0;
    int   accept_edge = 0;
    int   done_edge = 0;
    bit   prev_stall = 0;
    int   prev_type = 0;

    function automatic int coin_val(input int t);
        case (t)
            2:       return 10;
            1:       return 5;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic void load_greedy(input int c);
        int r;
        int n;
        exp_q.delete();
        r = c;
        n = r / 10; repeat (n) exp_q.push_back(2); r = r % 10;
        n = r / 5;  repeat (n) exp_q.push_back(1); r = r % 5;
        if (COIN2) begin
            n = r / 2; repeat (n) exp_q.push_back(3); r = r % 2;
        end
        repeat (r) exp_q.push_back(0);
    endfunction

    // Outputs are sampled on the falling edge; what the model expects for the
    // coming rising edge is updated after the checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            active     = 0;
            done_due   = 0;
            prev_stall = 0;
            exp_q.delete();
            exp_rem    = 0;
            exp_cnt    = 0;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_coin_valid", coin_valid, 0);
            check("rst_remaining", remaining, 0);
            check("rst_coin_count", coin_count, 0);
        end else begin
            check("busy", busy, active);
            check("done", done, done_due);
            check("remaining", remaining, exp_rem);
            check("coin_count", coin_count, exp_cnt);
            if (coin_valid && exp_q.size() > 0)
                check("coin_type", coin_type, exp_q[0]);
            else if (exp_q.size() == 0 || !active)
                check("coin_valid_idle", coin_valid, 0);
            if (prev_stall) begin
                check("valid_held", coin_valid, 1);
                check("type_held", coin_type, prev_type);
            end

            if (done_due) begin
                done_due  = 0;
                active    = 0;
                done_seen = 1;
                done_edge = cyc + 1;
            end else if (active && coin_valid && coin_ready && exp_q.size() > 0) begin
                obs_q.push_back(int'(coin_type));
                exp_rem = exp_rem - coin_val(exp_q[0]);
                exp_cnt = exp_cnt + 1;
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done_due = 1;
            end else if (!active && start) begin
                active      = 1;
                accept_edge = cyc + 1;
                done_seen   = 0;
                obs_q.delete();
                load_greedy(int'(change));
                exp_rem = int'(change);
                exp_cnt = 0;
                if (change == '0) done_due = 1;
            end
            prev_stall = coin_valid && !coin_ready;
            prev_type  = int'(coin_type);
        end
    end

    // ---------------------------------------------------------------- stimulus
    // Runs one payout; toggle=1 flips coin_ready every cycle, inject=1 raises
    // start with change=9 for three cycles while the payout is in progress.
    task automatic run_txn(input logic [W-1:0] chg, input bit toggle, input bit inject);
        int k;
        @(posedge clk); #1;
        start      = 1'b1;
        change     = chg;
        coin_ready = toggle ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        change = W'(3);
        k = 0;
        while (!done_seen && k < 200) begin
            if (toggle) coin_ready = ~coin_ready;
            if (inject && k >= 1 && k <= 3) begin
                start  = 1'b1;
                change = W'(9);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        check("done_timeout", done_seen, 1);
    endtask

    initial begin
        int k;
        rst_n      = 1'b1;
        start      = 1'b0;
        change     = '0;
        coin_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_coin_type", coin_type, 0);
        check("idle_remaining", remaining, 0);

        // 20 -> 10,10
        run_txn(W'(20), 1'b0, 1'b0);
        check("c20_coins", obs_q.size(), 2);
        check("c20_t0", obs_q[0], 2);
        check("c20_t1", obs_q[1], 2);
        check("c20_latency", done_edge - accept_edge, 5);
        check("c20_count", coin_count, 2);
        check("c20_remaining", remaining, 0);

        // 5 -> single 5-unit coin
        run_txn(W'(5), 1'b0, 1'b0);
        check("c5_coins", obs_q.size(), 1);
        check("c5_t0", obs_q[0], 1);
        check("c5_latency", done_edge - accept_edge, 3);
        check("c5_count", coin_count, 1);

        // 29 with coin_ready toggling
        run_txn(W'(29), 1'b1, 1'b0);
        if (COIN2) begin
            check("c29_coins", obs_q.size(), 5);
            check("c29_t3", obs_q[3], 3);
            check("c29_t4", obs_q[4], 3);
        end else begin
            check("c29_coins", obs_q.size(), 7);
            check("c29_t3", obs_q[3], 0);
            check("c29_t6", obs_q[6], 0);
        end
        check("c29_t0", obs_q[0], 2);
        check("c29_t1", obs_q[1], 2);
        check("c29_t2", obs_q[2], 1);
        repeat (2) @(posedge clk);
        #1;
        check("c29_count_held", coin_count, COIN2 ? 5 : 7);
        check("c29_rem_held", remaining, 0);

        // 7 exercises the optional 2-unit coin
        run_txn(W'(7), 1'b0, 1'b0);
        check("c7_coins", obs_q.size(), COIN2 ? 2 : 3);
        check("c7_t1", obs_q[1], COIN2 ? 3 : 0);

        // zero change: done right after accept, no coins
        run_txn(W'(0), 1'b0, 1'b0);
        check("c0_coins", obs_q.size(), 0);
        check("c0_latency", done_edge - accept_edge, 1);
        check("c0_count", coin_count, 0);

        // 13 with start/change=9 pushed while busy: must be ignored
        run_txn(W'(13), 1'b0, 1'b1);
        check("c13_coins", obs_q.size(), COIN2 ? 3 : 4);
        check("c13_t0", obs_q[0], 2);
        check("c13_latency", done_edge - accept_edge, COIN2 ? 7 : 9);
        check("c13_count", coin_count, COIN2 ? 3 : 4);
        repeat (2) @(posedge clk);
        #1;
        check("c13_no_requeue", busy, 0);

        // Abort a payout of 31 while a coin request is outstanding
        @(posedge clk); #1;
        start      = 1'b1;
        change     = W'(31);
        coin_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (obs_q.size() < 1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        coin_ready = 1'b0;
        k = 0;
        while (!coin_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_valid_before", coin_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid_drop", coin_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_remaining", remaining, 0);
        check("abort_count", coin_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_no_done", done_seen, 0);

        // Recovery: change=1 -> single 1-unit coin
        run_txn(W'(1), 1'b0, 1'b0);
        check("c1_coins", obs_q.size(), 1);
        check("c1_t0", obs_q[0], 0);
        check("c1_latency", done_edge - accept_edge, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run ends even if the stimulus gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $finish;
    end

endmodule
